// File: rtl/fpu_align_adder.sv
// rtl/fpu_align_adder.sv - align-and-add stage of the FPU add/subtract path
//
// Swaps the operands by magnitude, right-shifts the smaller mantissa to the
// larger exponent and adds/subtracts, producing an unnormalized result for
// fpu_normalizer.
//
// Configuration macro: FPU_ALIGN_BARREL_EN
//   defined   - single barrel shift at load time, fixed 2-cycle latency
//   undefined - serial one-bit-per-cycle alignment, latency shift+2
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake (in_ready high only in IDLE)
//   a, b               operands {sign, exponent, fraction}
//   sub                1 = a-b, 0 = a+b, sampled with the operands
//   out_valid/out_ready result handshake, result held until accepted
//   out_sign           result sign (+0 for a zero result)
//   out_exponent       exponent of the larger operand
//   out_mantissa       unnormalized magnitude, hidden bit at Mantissa_Size,
//                      carry at Mantissa_Size+1
//   out_zero           result magnitude is exactly zero
module fpu_align_adder #(
  parameter int Mantissa_Size = 23,
  parameter int Exponent_Size = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [Mantissa_Size+Exponent_Size:0]   a,
  input  logic [Mantissa_Size+Exponent_Size:0]   b,
  input  logic                                   sub,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_sign,
  output logic [Exponent_Size-1:0]               out_exponent,
  output logic [Mantissa_Size+1:0]               out_mantissa,
  output logic                                   out_zero
);

  localparam int MW  = Mantissa_Size + 1;   // mantissa including hidden bit
  localparam int CAP = Mantissa_Size + 2;   // shift cap, fully clears Y
  localparam int CW  = $clog2(CAP + 1);
  localparam logic [31:0] CAP_U = CAP;

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            count;
  logic [Exponent_Size-1:0] x_exp;
  logic [MW-1:0]            x_man;
  logic [MW-1:0]            y_man;
  logic                     x_sign;
  logic                     eff_sub;

  logic                     sign_a, sign_b;
  logic [Exponent_Size-1:0] exp_a, exp_b;
  logic [MW-1:0]            man_a, man_b;
  logic                     a_is_x;

  logic [Exponent_Size-1:0] ld_x_exp, ld_y_exp, diff;
  logic [MW-1:0]            ld_x_man, ld_y_man;
  logic                     ld_x_sign;
  logic [CW-1:0]            shamt;
  logic [MW:0]              sum;

  assign sign_a = a[Mantissa_Size+Exponent_Size];
  assign sign_b = b[Mantissa_Size+Exponent_Size];
  assign exp_a  = a[Mantissa_Size +: Exponent_Size];
  assign exp_b  = b[Mantissa_Size +: Exponent_Size];
  // Hidden bit from a nonzero exponent; denormal exponents are not rebiased.
  assign man_a  = {|exp_a, a[Mantissa_Size-1:0]};
  assign man_b  = {|exp_b, b[Mantissa_Size-1:0]};
  // Ties keep A as the larger operand.
  assign a_is_x = {exp_a, man_a} >= {exp_b, man_b};

  assign in_ready = (state == IDLE);

  always_comb begin
    ld_x_exp  = exp_a;
    ld_y_exp  = exp_b;
    ld_x_man  = man_a;
    ld_y_man  = man_b;
    ld_x_sign = sign_a;
    if (!a_is_x) begin
      ld_x_exp  = exp_b;
      ld_y_exp  = exp_a;
      ld_x_man  = man_b;
      ld_y_man  = man_a;
      ld_x_sign = sign_b ^ sub;
    end
    diff = ld_x_exp - ld_y_exp;
    if (32'(diff) > CAP_U) shamt = CW'(CAP);
    else                   shamt = CW'(diff);
  end

  // After the swap X >= aligned Y, so the difference never goes negative.
  always_comb begin
    sum = '0;
    if (eff_sub) sum = {1'b0, x_man} - {1'b0, y_man};
    else         sum = {1'b0, x_man} + {1'b0, y_man};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      x_exp        <= '0;
      x_man        <= '0;
      y_man        <= '0;
      x_sign       <= 1'b0;
      eff_sub      <= 1'b0;
      out_valid    <= 1'b0;
      out_sign     <= 1'b0;
      out_exponent <= '0;
      out_mantissa <= '0;
      out_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_exp   <= ld_x_exp;
            x_man   <= ld_x_man;
            x_sign  <= ld_x_sign;
            eff_sub <= sign_a ^ sign_b ^ sub;
`ifdef FPU_ALIGN_BARREL_EN
            y_man   <= ld_y_man >> shamt;
            count   <= '0;
`else
            y_man   <= ld_y_man;
            count   <= shamt;
`endif
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          if (count != '0) begin
            y_man <= y_man >> 1;
            count <= count - CW'(1);
          end else begin
            state <= ADD;
          end
        end
        ADD: begin
          out_mantissa <= sum;
          out_exponent <= x_exp;
          out_zero     <= (sum == '0);
          out_sign     <= x_sign & (sum != '0);
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_align_adder.sv
// tb/tb_fpu_align_adder.sv - scoreboard bench for fpu_align_adder
module tb_fpu_align_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [24:0] out_mantissa;
  logic        out_zero;

  fpu_align_adder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exponent(out_exponent),
    .out_mantissa(out_mantissa), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] man;
    logic        zero;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  bit   bp_en = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(string name, longint act, longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: signed-magnitude arithmetic on integer mantissas.
  function automatic exp_t model(logic [31:0] oa, logic [31:0] ob, logic osub, int acc);
    exp_t   r;
    longint ea, eb, ma, mb, ex, ey, mx, my, sh, res;
    bit     sa, sb, sx, sy;
    ea = oa[30:23];
    eb = ob[30:23];
    ma = (ea != 0 ? 64'(1) << 23 : 0) + oa[22:0];
    mb = (eb != 0 ? 64'(1) << 23 : 0) + ob[22:0];
    sa = oa[31];
    sb = ob[31] ^ osub;
    if (ea * 33554432 + ma >= eb * 33554432 + mb) begin
      ex = ea; mx = ma; sx = sa; ey = eb; my = mb; sy = sb;
    end else begin
      ex = eb; mx = mb; sx = sb; ey = ea; my = ma; sy = sa;
    end
    sh  = (ex - ey > 25) ? 25 : ex - ey;
    res = (sx ? -mx : mx) + (sy ? -(my >> sh) : (my >> sh));
    r.sign = (res < 0);
    r.man  = 25'(res < 0 ? -res : res);
    r.zero = (res == 0);
    r.exp  = 8'(ex);
`ifdef FPU_ALIGN_BARREL_EN
    r.lat  = 2;
`else
    r.lat  = int'(sh) + 2;
`endif
    r.acc  = acc;
    return r;
  endfunction

  task automatic send(logic [31:0] va, logic [31:0] vb, logic vs);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("send_timeout", 0, 1);
      return;
    end
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(model(va, vb, vs, cycle));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Monitor: latency on out_valid rise, hold stability, result on handshake.
  initial begin
    exp_t        cur;
    bit          prev = 0;
    logic [35:0] snap = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev = 0;
      end else begin
        if (out_valid && !prev) begin
          if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
          else begin
            cur = q[0];
            chk("latency", cycle - cur.acc, cur.lat);
          end
          snap = {out_sign, out_exponent, out_mantissa, out_zero, 1'b1};
        end else if (out_valid && prev) begin
          chk("hold_stable", {out_sign, out_exponent, out_mantissa, out_zero, 1'b1}, snap);
        end
        if (out_valid && out_ready && q.size() > 0) begin
          cur = q.pop_front();
          chk("out_sign", out_sign, cur.sign);
          chk("out_exponent", out_exponent, cur.exp);
          chk("out_mantissa", out_mantissa, cur.man);
          chk("out_zero", out_zero, cur.zero);
        end
        prev = out_valid && !out_ready;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int          n;
    int          ea, eb;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outputs", {out_sign, out_exponent, out_mantissa, out_zero}, 0);
    rst = 1'b0;

    send(32'h3F800000, 32'h3F800000, 1'b0); drain();
    send(32'h3F800000, 32'h3F000000, 1'b0); drain();
    send(32'h3F800000, 32'h40400000, 1'b1); drain();
    send(32'h3F800000, 32'h3F800000, 1'b1); drain();
    send(32'h3F800000, 32'h30800000, 1'b0); drain();
    send(32'h00400000, 32'h00200000, 1'b1); drain();

    // Backpressure in DONE with a competing in_valid.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h3F800000, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reached_done", out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      a = 32'h40000000; b = 32'h40000000; sub = 1'b0; in_valid = 1'b1;
      #2;
      chk("in_ready_busy", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (10) @(negedge clk);

    // Reset in the middle of a long alignment.
    send(32'h3F800000, 32'h30800000, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_outputs", {out_sign, out_exponent, out_mantissa, out_zero}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (35) @(negedge clk);

    bp_en = 1;
    for (int i = 0; i < 60; i++) begin
      ea = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) ea = 0;
      eb = ea + int'($urandom_range(0, 60)) - 30;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 5) == 0) rb = {1'($urandom_range(0, 1)), ra[30:0]};
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();
    bp_en = 0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
